// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, parameter defaults
// and small pattern helpers for active-low row/column vectors.
package keypad_pkg;

  localparam int SCAN_DIV_DEF       = 100000;
  localparam int DEBOUNCE_TICKS_DEF = 20;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    HOLD      = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  // True when exactly one bit of an active-low vector is asserted.
  function automatic logic one_low(input logic [3:0] v);
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    case (v)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] rotl(input logic [3:0] v);
    rotl = {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-clk strobe every SCAN_DIV clk cycles.
module tick_gen
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic [CW-1:0] cnt_r;

  // Wrap counter at SCAN_DIV-1 and register the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
      tick  <= 1'b0;
    end else begin
      if (cnt_r == LAST_C) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + ONE_C;
      end
      tick <= (cnt_r == LAST_C);
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column rotation, press/release debounce on scan
// ticks, hex key encoding and a four-deep history of accepted codes.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = SCAN_DIV_DEF,
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  kb_row,
  output logic [3:0]  kb_col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_pressed,
  output logic [15:0] key_data
);

  localparam int            CW    = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [3:0]    sync_meta_r;
  logic [3:0]    row_sync_r;
  logic [3:0]    row_s;
  logic          tick_s;
  state_t        state_r;
  logic [3:0]    row_cap_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_inc_s;
  logic [3:0]    code_s;

  tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  // Two-stage synchronizer for the asynchronous row lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta_r <= 4'b1111;
      row_sync_r  <= 4'b1111;
    end else begin
      sync_meta_r <= kb_row;
      row_sync_r  <= sync_meta_r;
    end
  end

  assign row_s = row_sync_r;

  // Saturating debounce increment and key code of the captured row/column.
  always_comb begin
    cnt_inc_s = cnt_r;
    if (cnt_r == DEB_C) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + ONE_C;
    end
    code_s = {low_idx(row_cap_r), low_idx(kb_col)};
  end

  // Scan/debounce FSM; the column stays frozen from capture until release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= SCAN;
      kb_col      <= 4'b1110;
      row_cap_r   <= 4'b1111;
      cnt_r       <= {CW{1'b0}};
      key_code    <= 4'h0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
      key_data    <= 16'h0000;
    end else begin
      key_valid <= 1'b0;
      if (tick_s) begin
        case (state_r)
          SCAN: begin
            if (one_low(row_s)) begin
              row_cap_r <= row_s;
              cnt_r     <= {CW{1'b0}};
              state_r   <= DEB_PRESS;
            end else begin
              kb_col <= rotl(kb_col);
            end
          end
          DEB_PRESS: begin
            if (row_s == row_cap_r) begin
              cnt_r <= cnt_inc_s;
              if (cnt_inc_s == DEB_C) begin
                key_valid   <= 1'b1;
                key_code    <= code_s;
                key_data    <= {key_data[11:0], code_s};
                key_pressed <= 1'b1;
                state_r     <= HOLD;
              end
            end else begin
              kb_col  <= rotl(kb_col);
              state_r <= SCAN;
            end
          end
          HOLD: begin
            if (row_s == 4'b1111) begin
              cnt_r   <= {CW{1'b0}};
              state_r <= DEB_REL;
            end
          end
          DEB_REL: begin
            if (row_s == 4'b1111) begin
              cnt_r <= cnt_inc_s;
              if (cnt_inc_s == DEB_C) begin
                key_pressed <= 1'b0;
                kb_col      <= rotl(kb_col);
                state_r     <= SCAN;
              end
            end else begin
              state_r <= HOLD;
            end
          end
          default: begin
            state_r <= SCAN;
            kb_col  <= 4'b1110;
            cnt_r   <= {CW{1'b0}};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a behavioural keypad matrix drives the rows
// from the scanned column, and a history model predicts accepted codes.
module tb_keypad_scan;

  localparam int S  = 4;
  localparam int DT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  kb_row;
  logic [3:0]  kb_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_pressed;
  logic [15:0] key_data;
  logic [15:0] keys_down;

  int   checks = 0;
  int   failures = 0;
  int   pulses = 0;
  int   b2b = 0;
  logic prev_valid = 1'b0;
  int   exp_data = 0;

  keypad_scan #(.SCAN_DIV(S), .DEBOUNCE_TICKS(DT)) dut (
    .clk         (clk),
    .rst         (rst),
    .kb_row      (kb_row),
    .kb_col      (kb_col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_pressed (key_pressed),
    .key_data    (key_data)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    kb_row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[r*4+c] && kb_col[c] == 1'b0) kb_row[r] = 1'b0;
  end

  // Pulse counter and back-to-back detector.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      pulses <= pulses + 1;
      if (prev_valid === 1'b1) b2b <= b2b + 1;
    end
    prev_valid <= key_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void model_accept(input int code);
    exp_data = (exp_data * 16 + code) % 65536;
  endfunction

  function automatic logic [3:0] col_drive(input int idx);
    logic [3:0] v;
    v = 4'b1111;
    v[idx % 4] = 1'b0;
    return v;
  endfunction

  function automatic int col_index(input logic [3:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < 4; i++) if (v === col_drive(i)) idx = i;
    return idx;
  endfunction

  task automatic wait_col(input logic [3:0] target, input string tag);
    int n;
    n = 0;
    while (kb_col !== target && n < 20*S) begin
      step(1);
      n++;
    end
    checks++;
    if (kb_col !== target) begin
      failures++;
      $display("FAIL %s: kb_col=%b, wanted %b within %0d clks", tag, kb_col, target, 20*S);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++; if (kb_col !== 4'b1110) begin failures++; $display("FAIL %s_col: got %b want 1110", tag, kb_col); end
    checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL %s_code: got %h want 0", tag, key_code); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL %s_valid: got %b want 0", tag, key_valid); end
    checks++; if (key_pressed !== 1'b0) begin failures++; $display("FAIL %s_pressed: got %b want 0", tag, key_pressed); end
    checks++; if (key_data !== 16'h0000) begin failures++; $display("FAIL %s_data: got %h want 0000", tag, key_data); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    keys_down = 16'h0000;
    exp_data = 0;
    step(3);
    check_reset_outputs("reset");
    rst = 1'b0;
  endtask

  task automatic test_single_press();
    int p0;
    p0 = pulses;
    keys_down = 16'h0001 << 6;
    step(12*S);
    model_accept(6);
    checks++; if (pulses - p0 != 1) begin failures++; $display("FAIL single_pulses: got %0d want 1", pulses - p0); end
    checks++; if (key_code !== 4'h6) begin failures++; $display("FAIL single_code: got %h want 6", key_code); end
    checks++; if (key_data !== 16'h0006) begin failures++; $display("FAIL single_data: got %h want 0006", key_data); end
    checks++; if (key_pressed !== 1'b1) begin failures++; $display("FAIL single_pressed: got %b want 1", key_pressed); end
    keys_down = 16'h0000;
    step(3*S);
    checks++; if (key_pressed !== 1'b1) begin failures++; $display("FAIL single_rel_early: got %b want 1", key_pressed); end
    step(3*S);
    checks++; if (key_pressed !== 1'b0) begin failures++; $display("FAIL single_rel_done: got %b want 0", key_pressed); end
    checks++; if (pulses - p0 != 1) begin failures++; $display("FAIL single_no_repeat: got %0d want 1", pulses - p0); end
  endtask

  task automatic test_bounce();
    int p0;
    keys_down = 16'h0000;
    wait_col(4'b0111, "bounce_sync");
    keys_down = 16'h0001 << 6;
    wait_col(4'b1011, "bounce_col2");
    p0 = pulses;
    step(2*S - 1);
    keys_down = 16'h0000;
    step(S);
    checks++; if (pulses - p0 != 0) begin failures++; $display("FAIL bounce_burst: got %0d pulses want 0", pulses - p0); end
    keys_down = 16'h0001 << 6;
    step(12*S);
    model_accept(6);
    checks++; if (pulses - p0 != 1) begin failures++; $display("FAIL bounce_pulses: got %0d want 1", pulses - p0); end
    checks++; if (key_data !== 16'(exp_data)) begin failures++; $display("FAIL bounce_data: got %h want %h", key_data, 16'(exp_data)); end
    keys_down = 16'h0000;
    step(8*S);
    checks++; if (key_pressed !== 1'b0) begin failures++; $display("FAIL bounce_release: got %b want 0", key_pressed); end
  endtask

  task automatic test_sequence();
    int p0;
    int codes[4];
    codes = '{1, 10, 3, 15};
    p0 = pulses;
    foreach (codes[i]) begin
      keys_down = 16'h0001 << codes[i];
      step(12*S);
      model_accept(codes[i]);
      checks++; if (key_code !== 4'(codes[i])) begin failures++; $display("FAIL seq_code%0d: got %h want %h", i, key_code, 4'(codes[i])); end
      keys_down = 16'h0000;
      step(8*S);
    end
    checks++; if (pulses - p0 != 4) begin failures++; $display("FAIL seq_pulses: got %0d want 4", pulses - p0); end
    checks++; if (key_data !== 16'h1A3F) begin failures++; $display("FAIL seq_data: got %h want 1a3f", key_data); end
  endtask

  task automatic test_hold_second();
    int p0;
    int bad;
    p0 = pulses;
    bad = 0;
    keys_down = 16'h0001 << 6;
    step(12*S);
    model_accept(6);
    keys_down = keys_down | (16'h0001 << 10);
    for (int i = 0; i < 8*S; i++) begin
      step(1);
      if (kb_col !== 4'b1011 || key_pressed !== 1'b1) bad++;
    end
    keys_down = 16'h0001 << 10;
    for (int i = 0; i < 8*S; i++) begin
      step(1);
      if (kb_col !== 4'b1011 || key_pressed !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL hold_frozen: got %0d bad cycles want 0", bad); end
    checks++; if (pulses - p0 != 1) begin failures++; $display("FAIL hold_pulses: got %0d want 1", pulses - p0); end
    keys_down = 16'h0000;
    step(8*S);
    checks++; if (key_pressed !== 1'b0) begin failures++; $display("FAIL hold_release: got %b want 0", key_pressed); end
    checks++; if (key_data !== 16'(exp_data)) begin failures++; $display("FAIL hold_data: got %h want %h", key_data, 16'(exp_data)); end
  endtask

  task automatic test_two_rows();
    int p0;
    int changes;
    int bad;
    int idx;
    logic [3:0] prev;
    p0 = pulses;
    changes = 0;
    bad = 0;
    keys_down = (16'h0001 << 6) | (16'h0001 << 10);
    prev = kb_col;
    idx = col_index(kb_col);
    for (int i = 0; i < 8*S; i++) begin
      step(1);
      if (kb_col !== prev) begin
        changes++;
        if (idx < 0 || kb_col !== col_drive(idx + 1)) bad++;
        idx = col_index(kb_col);
        prev = kb_col;
      end
    end
    checks++; if (changes != 8) begin failures++; $display("FAIL two_rows_rotations: got %0d want 8", changes); end
    checks++; if (bad != 0) begin failures++; $display("FAIL two_rows_order: got %0d bad steps want 0", bad); end
    checks++; if (pulses - p0 != 0) begin failures++; $display("FAIL two_rows_pulses: got %0d want 0", pulses - p0); end
    keys_down = 16'h0000;
    step(2*S);
  endtask

  task automatic test_random();
    int p0;
    int k;
    int g;
    for (int it = 0; it < 6; it++) begin
      g = $urandom_range(0, 15);
      keys_down = 16'h0001 << g;
      step($urandom_range(1, S - 1));
      keys_down = 16'h0000;
      step(2*S);
      k = $urandom_range(0, 15);
      p0 = pulses;
      keys_down = 16'h0001 << k;
      step($urandom_range(12, 18) * S);
      model_accept(k);
      checks++; if (pulses - p0 != 1) begin failures++; $display("FAIL rand%0d_pulses: got %0d want 1", it, pulses - p0); end
      checks++; if (key_code !== 4'(k)) begin failures++; $display("FAIL rand%0d_code: got %h want %h", it, key_code, 4'(k)); end
      checks++; if (key_data !== 16'(exp_data)) begin failures++; $display("FAIL rand%0d_data: got %h want %h", it, key_data, 16'(exp_data)); end
      checks++; if (key_pressed !== 1'b1) begin failures++; $display("FAIL rand%0d_pressed: got %b want 1", it, key_pressed); end
      keys_down = 16'h0000;
      step($urandom_range(8, 12) * S);
      checks++; if (key_pressed !== 1'b0) begin failures++; $display("FAIL rand%0d_release: got %b want 0", it, key_pressed); end
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    keys_down = 16'h0000;
    wait_col(4'b0111, "rstmid_sync");
    keys_down = 16'h0001 << 6;
    wait_col(4'b1011, "rstmid_col2");
    step(S + 2);
    p0 = pulses;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rstmid");
    step(2);
    rst = 1'b0;
    exp_data = 0;
    step(12*S);
    model_accept(6);
    checks++; if (pulses - p0 != 1) begin failures++; $display("FAIL rstmid_pulses: got %0d want 1", pulses - p0); end
    checks++; if (key_code !== 4'h6) begin failures++; $display("FAIL rstmid_code: got %h want 6", key_code); end
    checks++; if (key_data !== 16'(exp_data)) begin failures++; $display("FAIL rstmid_data: got %h want %h", key_data, 16'(exp_data)); end
    keys_down = 16'h0000;
    step(8*S);
    checks++; if (key_pressed !== 1'b0) begin failures++; $display("FAIL rstmid_release: got %b want 0", key_pressed); end
  endtask

  task automatic test_back_to_back();
    checks++;
    if (b2b != 0) begin
      failures++;
      $display("FAIL valid_b2b: got %0d consecutive-high events want 0", b2b);
    end
  endtask

  initial begin
    rst = 1'b1;
    keys_down = 16'h0000;
    test_reset();
    test_single_press();
    test_bounce();
    test_sequence();
    test_hold_second();
    test_two_rows();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
